// File: rtl/lcd_pkg.sv
// Shared types, state codes and HD44780-style command constants for the LCD
// character write controller.
package lcd_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned PHASE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_INIT_FUNC  = 3'd0;
  localparam state_t ST_INIT_DISP  = 3'd1;
  localparam state_t ST_INIT_ENTRY = 3'd2;
  localparam state_t ST_INIT_CLR   = 3'd3;
  localparam state_t ST_IDLE       = 3'd4;
  localparam state_t ST_SET_ADDR   = 3'd5;
  localparam state_t ST_WR_CHAR    = 3'd6;

  localparam logic [PHASE_W-1:0] PH_IDLE  = 2'd0;
  localparam logic [PHASE_W-1:0] PH_SETUP = 2'd1;
  localparam logic [PHASE_W-1:0] PH_PULSE = 2'd2;
  localparam logic [PHASE_W-1:0] PH_HOLD  = 2'd3;

  localparam logic [DATA_W-1:0] CMD_FUNC_SET  = 8'h38;
  localparam logic [DATA_W-1:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [DATA_W-1:0] CMD_ENTRY     = 8'h06;
  localparam logic [DATA_W-1:0] CMD_CLEAR     = 8'h01;
  localparam logic [DATA_W-1:0] CMD_ADDR_ROW0 = 8'h80;
  localparam logic [DATA_W-1:0] CMD_ADDR_ROW1 = 8'hC0;

  // One word on the LCD bus: register select plus data byte.
  typedef struct packed {
    logic              rs;
    logic [DATA_W-1:0] data;
  } lcd_word_t;

  function automatic lcd_word_t cmd_word(input logic [DATA_W-1:0] c);
    lcd_word_t w;
    w.rs   = 1'b0;
    w.data = c;
    return w;
  endfunction

  // DDRAM address command: bit4 selects the row, bits3:0 the column.
  function automatic logic [DATA_W-1:0] addr_cmd(input logic [POS_W-1:0] p);
    return (p[4] ? CMD_ADDR_ROW1 : CMD_ADDR_ROW0) | {4'h0, p[3:0]};
  endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single LCD bus transfer: SETUP -> PULSE -> HOLD, each phase advanced by en_clk.
// rs/data are captured at start and held until the transfer completes.
module lcd_xfer
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_clk,
  input  logic              start,
  input  logic              rs,
  input  logic [DATA_W-1:0] data,
  output logic              xfer_done,
  output logic              lcd_rs,
  output logic              lcd_e,
  output logic [DATA_W-1:0] lcd_data
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               e_d, rs_d;
  logic [DATA_W-1:0]  data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_IDLE;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      phase_q  <= phase_d;
      lcd_e    <= e_d;
      lcd_rs   <= rs_d;
      lcd_data <= data_d;
    end
  end

  // A new start may chain directly onto the completing HOLD phase.
  always_comb begin
    phase_d   = phase_q;
    e_d       = lcd_e;
    rs_d      = lcd_rs;
    data_d    = lcd_data;
    xfer_done = 1'b0;
    case (phase_q)
      PH_SETUP: if (en_clk) begin
        phase_d = PH_PULSE;
        e_d     = 1'b1;
      end
      PH_PULSE: if (en_clk) begin
        phase_d = PH_HOLD;
        e_d     = 1'b0;
      end
      PH_HOLD: if (en_clk) begin
        phase_d   = PH_IDLE;
        rs_d      = 1'b0;
        data_d    = '0;
        xfer_done = 1'b1;
      end
      default: ;
    endcase
    if (start && ((phase_q == PH_IDLE) || xfer_done)) begin
      phase_d = PH_SETUP;
      e_d     = 1'b0;
      rs_d    = rs;
      data_d  = data;
    end
  end

endmodule

// File: rtl/lcd_write_ctrl.sv
// LCD character write controller: power-up init sequence, then one
// address + data transfer pair per accepted request.
module lcd_write_ctrl
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_clk,
  input  logic              req,
  input  logic [POS_W-1:0]  pos,
  input  logic [DATA_W-1:0] char_code,
  output logic              ready,
  output logic              done,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [DATA_W-1:0] lcd_data
);

  state_t            state_q, state_d;
  logic              kick_q;
  logic [DATA_W-1:0] char_q, char_d;
  logic              ready_d, done_d;
  logic              xfer_done;
  logic              start_c;
  lcd_word_t         start_word_c;

  assign lcd_rw = 1'b0;

  // kick_q launches the first init transfer on the cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT_FUNC;
      kick_q  <= 1'b1;
      char_q  <= '0;
      ready   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      kick_q  <= 1'b0;
      char_q  <= char_d;
      ready   <= ready_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    char_d       = char_q;
    done_d       = 1'b0;
    ready_d      = 1'b0;
    start_c      = 1'b0;
    start_word_c = '0;

    case (state_q)
      ST_INIT_FUNC:  if (xfer_done) state_d = ST_INIT_DISP;
      ST_INIT_DISP:  if (xfer_done) state_d = ST_INIT_ENTRY;
      ST_INIT_ENTRY: if (xfer_done) state_d = ST_INIT_CLR;
      ST_INIT_CLR:   if (xfer_done) state_d = ST_IDLE;
      ST_IDLE: if (req && ready) begin
        state_d = ST_SET_ADDR;
        char_d  = char_code;
      end
      ST_SET_ADDR:   if (xfer_done) state_d = ST_WR_CHAR;
      ST_WR_CHAR: if (xfer_done) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_INIT_FUNC;
    endcase

    ready_d = (state_d == ST_IDLE);

    // Every entry into a transfer state launches that state's transfer.
    start_c = kick_q || ((state_d != state_q) && (state_d != ST_IDLE));
    case (state_d)
      ST_INIT_FUNC:  start_word_c = cmd_word(CMD_FUNC_SET);
      ST_INIT_DISP:  start_word_c = cmd_word(CMD_DISP_ON);
      ST_INIT_ENTRY: start_word_c = cmd_word(CMD_ENTRY);
      ST_INIT_CLR:   start_word_c = cmd_word(CMD_CLEAR);
      ST_SET_ADDR:   start_word_c = cmd_word(addr_cmd(pos));
      ST_WR_CHAR: begin
        start_word_c.rs   = 1'b1;
        start_word_c.data = char_q;
      end
      default:       start_word_c = '0;
    endcase
  end

  lcd_xfer u_xfer (
    .clk       (clk),
    .rst       (rst),
    .en_clk    (en_clk),
    .start     (start_c),
    .rs        (start_word_c.rs),
    .data      (start_word_c.data),
    .xfer_done (xfer_done),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl: init sequence, writes, back-to-back
// requests, ignored requests, en_clk stall and reset mid-transfer.
module tb_lcd_write_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_clk = 1'b0;
  logic       req = 1'b0;
  logic [4:0] pos = '0;
  logic [7:0] char_code = '0;
  logic       ready, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  int tests = 0;
  int fails = 0;
  bit tick_en = 1'b0;
  int gen_cnt = 0;
  int tick_seen = 0;
  int done_cnt = 0;
  logic prev_e = 1'b0;
  logic [8:0] xq[$];

  lcd_write_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en_clk    (en_clk),
    .req       (req),
    .pos       (pos),
    .char_code (char_code),
    .ready     (ready),
    .done      (done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tick counter sees en_clk as the DUT samples it; ticks issued every 4 clk.
  always @(posedge clk) begin
    if (en_clk) tick_seen++;
    #1;
    gen_cnt = (gen_cnt + 1) % 4;
    en_clk  = tick_en && (gen_cnt == 0);
  end

  // Record every enable pulse as {rs,data}; bus must not move until e falls.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (lcd_e && !prev_e) xq.push_back({lcd_rs, lcd_data});
    if (!lcd_e && prev_e && !rst && xq.size() > 0)
      check("bus_stable_through_pulse", 32'({lcd_rs, lcd_data}), 32'(xq[$]));
    prev_e = lcd_e;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return ready;
      1:       return done;
      2:       return lcd_e && !lcd_rs;
      default: return lcd_e && lcd_rs;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int bound);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      step();
      if (cond(which)) hit = 1'b1;
    end
    if (!hit) check($sformatf("wait_timeout_%0d", which), 32'(hit), 32'd1);
  endtask

  initial begin
    int t0, n, dsave;

    // Reset values
    repeat (3) step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h00);

    // Init sequence, with a request pulse that must be ignored
    rst = 1'b0;
    tick_en = 1'b1;
    t0 = tick_seen;
    step();
    check("init_first_setup_data", 32'(lcd_data), 32'h38);
    check("init_first_setup_e", 32'(lcd_e), 32'd0);
    check("init_first_setup_rs", 32'(lcd_rs), 32'd0);
    repeat (10) step();
    pos = 5'h01; char_code = 8'h55; req = 1'b1;
    step();
    req = 1'b0;
    wait_cond(0, 200);
    check("init_ticks_to_ready", 32'(tick_seen - t0), 32'd12);
    check("init_xfer_count", 32'(xq.size()), 32'd4);
    if (xq.size() == 4) begin
      check("init_cmd0", 32'(xq[0]), 32'h038);
      check("init_cmd1", 32'(xq[1]), 32'h00C);
      check("init_cmd2", 32'(xq[2]), 32'h006);
      check("init_cmd3", 32'(xq[3]), 32'h001);
    end
    check("init_no_done", 32'(done_cnt), 32'd0);
    check("idle_data", 32'(lcd_data), 32'h00);
    xq.delete();

    // Single write, row 1 col 3; inputs scrambled after acceptance
    pos = 5'h13; char_code = 8'h41; req = 1'b1;
    step();
    check("accept_ready_drop", 32'(ready), 32'd0);
    t0 = tick_seen;
    req = 1'b0; pos = 5'h0A; char_code = 8'hEE;
    wait_cond(1, 200);
    check("wr_ticks_to_done", 32'(tick_seen - t0), 32'd6);
    check("wr_done_ready", 32'(ready), 32'd1);
    check("wr_done_rs", 32'(lcd_rs), 32'd0);
    check("wr_done_data", 32'(lcd_data), 32'h00);
    check("wr_xfer_count", 32'(xq.size()), 32'd2);
    if (xq.size() == 2) begin
      check("wr_addr", 32'(xq[0]), 32'h0C3);
      check("wr_char", 32'(xq[1]), 32'h141);
    end
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("wr_done_count", 32'(done_cnt), 32'd1);
    xq.delete();

    // req held high: three back-to-back writes
    pos = 5'h00; char_code = 8'h30; req = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 3; i++) begin
      step();
      if (done) begin
        n++;
        if (n == 3) req = 1'b0;
      end
    end
    req = 1'b0;
    check("b2b_done_seen", 32'(n), 32'd3);
    repeat (30) step();
    check("b2b_xfer_count", 32'(xq.size()), 32'd6);
    for (int i = 0; i < 6 && i < xq.size(); i++)
      check($sformatf("b2b_xfer%0d", i), 32'(xq[i]), (i % 2 == 1) ? 32'h130 : 32'h080);
    check("b2b_done_count", 32'(done_cnt), 32'd4);
    check("b2b_idle_ready", 32'(ready), 32'd1);
    xq.delete();

    // Request pulsed mid-write must be dropped
    pos = 5'h1F; char_code = 8'h7A; req = 1'b1;
    step();
    req = 1'b0;
    repeat (8) step();
    pos = 5'h05; char_code = 8'h21; req = 1'b1;
    step();
    req = 1'b0;
    wait_cond(1, 200);
    repeat (40) step();
    check("ign_xfer_count", 32'(xq.size()), 32'd2);
    if (xq.size() == 2) begin
      check("ign_addr", 32'(xq[0]), 32'h0CF);
      check("ign_char", 32'(xq[1]), 32'h17A);
    end
    check("ign_done_count", 32'(done_cnt), 32'd5);
    xq.delete();

    // en_clk stalled during the address PULSE
    pos = 5'h02; char_code = 8'h42; req = 1'b1;
    step();
    req = 1'b0;
    wait_cond(2, 100);
    tick_en = 1'b0;
    repeat (100) step();
    check("stall_e_high", 32'(lcd_e), 32'd1);
    check("stall_data", 32'(lcd_data), 32'h82);
    check("stall_rs", 32'(lcd_rs), 32'd0);
    check("stall_no_new_xfer", 32'(xq.size()), 32'd1);
    tick_en = 1'b1;
    wait_cond(1, 200);
    check("stall_xfer_count", 32'(xq.size()), 32'd2);
    if (xq.size() == 2) begin
      check("stall_addr", 32'(xq[0]), 32'h082);
      check("stall_char", 32'(xq[1]), 32'h142);
    end
    check("stall_done_count", 32'(done_cnt), 32'd6);
    xq.delete();

    // Reset during the data PULSE: init restarts, no done
    pos = 5'h10; char_code = 8'h58; req = 1'b1;
    step();
    req = 1'b0;
    wait_cond(3, 200);
    check("rst_mid_pre_addr", (xq.size() > 0) ? 32'(xq[0]) : 32'h1FF, 32'h0C0);
    rst = 1'b1;
    tick_en = 1'b0;
    dsave = done_cnt;
    step();
    check("rst_mid_e", 32'(lcd_e), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_data", 32'(lcd_data), 32'h00);
    step();
    rst = 1'b0;
    tick_en = 1'b1;
    xq.delete();
    t0 = tick_seen;
    wait_cond(0, 200);
    check("reinit_ticks", 32'(tick_seen - t0), 32'd12);
    check("reinit_xfer_count", 32'(xq.size()), 32'd4);
    check("reinit_first", (xq.size() > 0) ? 32'(xq[0]) : 32'h1FF, 32'h038);
    check("reinit_no_done", 32'(done_cnt), 32'(dsave));
    check("rw_low", 32'(lcd_rw), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_write_ctrl.md
LCD_WRITE_CTRL -- requirements
Module: lcd_write_ctrl

Interface
REQ-001 clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 en_clk  input  1  one-clk-wide pacing tick, one every 2 ms; all LCD bus phase changes are paced by it.
REQ-004 req  input  1  character write request, sampled only while ready=1.
REQ-005 pos  input  5  target cell: bit4 = row (0/1), bits3:0 = column 0-15.
REQ-006 char  input  8  character code for the target cell.
REQ-007 ready  output  1  high when idle, init complete and a request can be accepted.
REQ-008 done  output  1  one-clk pulse when an accepted write has fully completed.
REQ-009 lcd_rs  output  1  LCD register select: 0 = command, 1 = data.
REQ-010 lcd_rw  output  1  LCD read/write; constant 0.
REQ-011 lcd_e  output  1  LCD enable strobe.
REQ-012 lcd_data  output  8  LCD data bus, 8-bit mode.

Function
REQ-013 Transfer unit: SETUP (rs/data driven, e=0) -> next en_clk -> PULSE (e=1) -> next en_clk -> HOLD (e=0) -> next en_clk -> transfer complete; 3 ticks per transfer.
REQ-014 lcd_rs and lcd_data shall remain stable from SETUP entry until transfer complete.
REQ-015 Sequencer states: INIT_FUNC, INIT_DISP, INIT_ENTRY, INIT_CLR, IDLE, SET_ADDR, WR_CHAR.
REQ-016 Init sequence: commands 0x38, 0x0C, 0x06, 0x01, in that order, rs=0; each state performs one transfer.
REQ-017 The first init SETUP begins on the first cycle after rst deasserts; IDLE is entered on the clk edge that samples the 12th en_clk tick.
REQ-018 ready=1 only in IDLE; req=1 with ready=1 latches pos and char, enters SET_ADDR and drops ready on the same edge.
REQ-019 req while ready=0 shall be ignored, not queued.
REQ-020 SET_ADDR sends command 0x80|col for row 0 and 0xC0|col for row 1, rs=0.
REQ-021 WR_CHAR sends the latched char with rs=1.
REQ-022 An en_clk tick arriving in the accept cycle is not counted; counting begins in the cycle after acceptance.
REQ-023 On the edge sampling the 6th counted tick after acceptance: done=1 for one cycle, ready=1, state=IDLE, lcd_rs=0, lcd_data=0x00.
REQ-024 Changes on pos/char after acceptance shall not affect the transfer in progress.
REQ-025 en_clk stuck low shall freeze the current phase indefinitely, with outputs held.

Reset
REQ-026 On rst: state=INIT_FUNC/SETUP, ready=0, done=0, lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_data=0x00, latches cleared.
REQ-027 rst asserted mid-transfer shall force lcd_e=0 on the next edge and restart the full init sequence, with no done pulse.

Structure
REQ-028 Shared package lcd_pkg shall hold the state enum and the command constants 0x38, 0x0C, 0x06, 0x01, 0x80 and 0xC0.
REQ-029 One sub-module, lcd_xfer, shall implement the 3-phase transfer; it takes start, rs, data and en_clk, and returns xfer_done.
REQ-030 lcd_write_ctrl shall contain only the sequencer FSM, request latch and handshake.

Verification
REQ-031 Reset release with en_clk every 4 clk: observe lcd_data sequence 0x38, 0x0C, 0x06, 0x01, each with one e pulse; ready rises on the 12th tick.
REQ-032 req with pos=5'h13, char=0x41: observe 0xC3 (rs=0), then 0x41 (rs=1); done pulses once on the 6th tick; ready=1 on the same cycle.
REQ-033 req held high continuously with pos=0, char=0x30: back-to-back writes; each write is accepted only when ready=1, with no missing or extra transfers.
REQ-034 req pulsed while ready=0, during init and mid-write: no effect on lcd_data, and no extra done pulse.
REQ-035 rst asserted during PULSE of WR_CHAR: lcd_e=0 on the next edge, no done pulse, and the init sequence restarts at 0x38.
REQ-036 en_clk held low 100 cycles during PULSE: lcd_e stays 1 with lcd_data stable, then resumes correctly when ticks return.
